fetch_window_aligner: RTL and testbench
=======================================

Name: fetch_window_aligner

Overview:
- Stage directly upstream of the fetch requester. Accepts whole LINE_SIZE-bit message lines from the line fetch path and keeps a byte cursor into them.
- Presents a byte-aligned WINDOW_BYTES window starting at the cursor. This window is the encoded varint header fed to the requester's decoder.
- The consumer returns the decoded byte count, and the cursor advances by that count. Windows that straddle two lines are handled by a two-line buffer.

Parameters:
- LINE_SIZE, 512: line width in bits. LINE_SIZE/8 must be a power of two.
- WINDOW_BYTES, 10: output window size in bytes. 10 covers a max-length 64-bit varint.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- line_valid  input  1  upstream line available
- line_ready  output  1  aligner can accept a line
- line_data  input  LINE_SIZE  line bytes; byte k is at bits [8k+7:8k]
- line_last  input  1  line is the final line of the message
- flush  input  1  synchronous discard of all buffered state
- win_valid  output  1  window holds meaningful bytes
- win_data  output  8*WINDOW_BYTES  window; byte i is at bits [8i+7:8i]
- win_bytes  output  $clog2(WINDOW_BYTES+1)  count of valid window bytes, min(buffered, WINDOW_BYTES)
- consume_valid  input  1  consumer advances the cursor
- consume_bytes  input  $clog2(WINDOW_BYTES+1)  bytes to advance, 1..WINDOW_BYTES
- msg_done  output  1  one-cycle pulse when the last byte of a last-tagged line is consumed
- err  output  1  sticky over-consume error

Behaviour:
- State:
  - cur_vld/cur_data/cur_last and nxt_vld/nxt_data/nxt_last.
  - cursor, $clog2(LB) bits, where LB = LINE_SIZE/8.
  - err and msg_done registers.
- Reset (rst_n low, asynchronous): all valids 0, cursor 0, err 0, msg_done 0.
  - Consequences: win_valid 0, win_data 0, win_bytes 0, line_ready 1 after reset is released.
- line_ready = !nxt_vld. It is a combinational decode of registered state and has no path from the consume inputs.
- Line accept occurs on line_valid && line_ready at an edge:
  - Loads cur if cur is empty, or will empty this cycle.
  - Otherwise loads nxt.
  - The window reflects the new line on the next cycle; accept-to-window latency is 1 cycle.
- avail:
  - (cur_vld ? LB-cursor : 0) + (nxt_vld ? LB : 0).
  - Compute at the full width needed for 2*LB. Do not truncate.
- last_buf = (nxt_vld ? nxt_last : cur_vld && cur_last).
- win_valid = cur_vld && (avail >= WINDOW_BYTES || last_buf).
- win_data:
  - Byte i = byte (cursor+i) of {nxt_data, cur_data}, for i < min(avail, WINDOW_BYTES).
  - Remaining bytes read 0.
  - When win_valid is 0, win_data reads 0.
- Consume fires on consume_valid && win_valid && 1 <= consume_bytes <= win_bytes.
  - sum = cursor + consume_bytes, computed one bit wider than cursor.
  - If sum >= LB: cur <= nxt (including last flag), nxt_vld <= 0, cursor <= sum - LB.
  - Otherwise cursor <= sum.
  - Effects are visible the next cycle.
- Simultaneous consume that empties cur and a line accept: the incoming line lands in the slot vacated by the shift. No line is lost and none is duplicated.
- consume_bytes == 0 is a no-op. consume_valid while win_valid == 0 is ignored.
- Over-consume (consume_valid && win_valid && consume_bytes > win_bytes):
  - err set, sticky until reset or flush.
  - Cursor and buffers are unchanged.
- msg_done pulses 1 cycle after a consume that leaves zero bytes, provided the consumed line had last set. Cursor returns to 0 and both slots are empty.
- flush:
  - Clears valids, cursor, err and msg_done at the edge.
  - Priority over accept and consume in the same cycle; the line offered that cycle is not accepted.
- Reset mid-operation: asynchronous clear as above. A partially consumed line is discarded.

Decomposition:
- fetch_pkg holds:
  - LINE_BYTES and WINDOW_BYTES localparams.
  - typedefs line_t, window_t, cursor_t, bytecnt_t.
- Sub-module fetch_byte_funnel: combinational funnel shift. Inputs: {nxt, cur}, cursor, avail. Outputs: win_data and win_bytes.
- The aligner keeps all state and control.

Test Plan:
- Reset, then one line of bytes 0x00..0x3F with last=0 -> next cycle: win_valid=1, win_bytes=10, win_data bytes 0x00..0x09, line_ready=1.
- Two lines (0x00..0x3F, 0x40..0x7F). Consume 10,10,10,10,10,10 reaches cursor 60 -> window is 0x3C..0x45. Consume 6 -> cur<=second line, cursor 2, line_ready rises next cycle.
- Single last line. Advance cursor to 58 -> win_bytes=6, win_valid=1, bytes 6..9 zero. Consume 6 -> msg_done pulses once, win_valid=0. Consume 7 instead -> err=1, cursor stays 58.
- Both slots full, line_valid held high -> line_ready=0 and no accept. Pop-crossing consume together with line_valid -> third line lands in nxt, window contiguous across the boundary.
- Mid-stream flush asserted together with consume_valid and line_valid -> next cycle all empty, err=0, cursor 0, offered line not taken. Repeat with rst_n pulsed low between edges -> outputs clear immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared sizes and types for the fetch window aligner.
package fetch_pkg;
    localparam int LINE_SIZE    = 512;
    localparam int LINE_BYTES   = LINE_SIZE / 8;
    localparam int WINDOW_BYTES = 10;
    localparam int CW           = $clog2(LINE_BYTES);
    localparam int BW           = $clog2(WINDOW_BYTES + 1);
    localparam int AW           = $clog2(2 * LINE_BYTES + 1);
    typedef logic [LINE_SIZE-1:0]      line_t;
    typedef logic [8*WINDOW_BYTES-1:0] window_t;
    typedef logic [CW-1:0]             cursor_t;
    typedef logic [BW-1:0]             bytecnt_t;
    typedef logic [AW-1:0]             avail_t;
endpackage

// File: rtl/fetch_window_aligner_if.sv
// fetch_window_aligner_if: line input, window output and consume handshake bundle.
//   master: line source / window consumer side; slave: the aligner.
interface fetch_window_aligner_if;
    import fetch_pkg::*;
    logic     line_valid;
    logic     line_ready;
    line_t    line_data;
    logic     line_last;
    logic     flush;
    logic     win_valid;
    window_t  win_data;
    bytecnt_t win_bytes;
    logic     consume_valid;
    bytecnt_t consume_bytes;
    logic     msg_done;
    logic     err;
    modport master (
        output line_valid, line_data, line_last, flush, consume_valid, consume_bytes,
        input  line_ready, win_valid, win_data, win_bytes, msg_done, err
    );
    modport slave (
        input  line_valid, line_data, line_last, flush, consume_valid, consume_bytes,
        output line_ready, win_valid, win_data, win_bytes, msg_done, err
    );
endinterface

// File: rtl/fetch_byte_funnel.sv
// fetch_byte_funnel: combinational byte funnel selecting a window at the cursor.
//   buf_data: {nxt, cur} lines; cursor: start byte; avail: buffered bytes
//   win_data: window bytes (unused bytes zero); win_bytes: min(avail, WINDOW_BYTES)
module fetch_byte_funnel
    import fetch_pkg::*;
(
    input  logic [2*LINE_SIZE-1:0] buf_data,
    input  cursor_t                cursor,
    input  avail_t                 avail,
    output window_t                win_data,
    output bytecnt_t               win_bytes
);
    logic [2*LINE_SIZE-1:0] shifted;
    always_comb begin
        win_bytes = (avail >= avail_t'(WINDOW_BYTES)) ? bytecnt_t'(WINDOW_BYTES) : bytecnt_t'(avail);
        shifted   = buf_data >> {cursor, 3'b000};
        win_data  = '0;
        for (int i = 0; i < WINDOW_BYTES; i++)
            win_data[8*i +: 8] = (i < int'(win_bytes)) ? shifted[8*i +: 8] : 8'h00;
    end
endmodule

// File: rtl/fetch_window_aligner.sv
// fetch_window_aligner: two-line buffer with byte cursor presenting a varint header window.
//   clk, rst_n (async active-low); bus: line input, window output, consume, flush, msg_done, err
module fetch_window_aligner
    import fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_window_aligner_if.slave bus
);
    localparam logic [CW:0] LB_W = (CW+1)'(LINE_BYTES);
    logic     cur_vld_q, cur_vld_d, cur_last_q, cur_last_d;
    logic     nxt_vld_q, nxt_vld_d, nxt_last_q, nxt_last_d;
    line_t    cur_data_q, cur_data_d, nxt_data_q, nxt_data_d;
    cursor_t  cursor_q, cursor_d;
    logic     err_q, err_d, msg_done_q, msg_done_d;
    avail_t   avail;
    logic     last_buf, win_valid, hit, fire, over, pop, accept;
    logic [CW:0] sum;
    window_t  fun_data;
    bytecnt_t fun_bytes;

    fetch_byte_funnel u_funnel (
        .buf_data  ({nxt_data_q, cur_data_q}),
        .cursor    (cursor_q),
        .avail     (avail),
        .win_data  (fun_data),
        .win_bytes (fun_bytes)
    );

    assign bus.line_ready = !nxt_vld_q;
    assign bus.win_valid  = win_valid;
    assign bus.win_data   = win_valid ? fun_data : '0;
    assign bus.win_bytes  = fun_bytes;
    assign bus.msg_done   = msg_done_q;
    assign bus.err        = err_q;

    always_comb begin
        avail      = (cur_vld_q ? avail_t'(LINE_BYTES) - avail_t'(cursor_q) : '0)
                   + (nxt_vld_q ? avail_t'(LINE_BYTES) : '0);
        last_buf   = nxt_vld_q ? nxt_last_q : (cur_vld_q && cur_last_q);
        win_valid  = cur_vld_q && (avail >= avail_t'(WINDOW_BYTES) || last_buf);
        hit        = bus.consume_valid && win_valid;
        fire       = hit && bus.consume_bytes != '0 && bus.consume_bytes <= fun_bytes;
        over       = hit && bus.consume_bytes > fun_bytes;
        sum        = {1'b0, cursor_q} + (CW+1)'(bus.consume_bytes);
        pop        = fire && sum >= LB_W;
        accept     = bus.line_valid && !nxt_vld_q;
        cur_vld_d  = cur_vld_q;
        cur_last_d = cur_last_q;
        cur_data_d = cur_data_q;
        nxt_vld_d  = nxt_vld_q;
        nxt_last_d = nxt_last_q;
        nxt_data_d = nxt_data_q;
        cursor_d   = cursor_q;
        err_d      = err_q || over;
        // Consuming the whole buffer is only possible with nxt empty, so this marks message end.
        msg_done_d = pop && !nxt_vld_q && cur_last_q;
        if (pop) begin
            cur_vld_d  = nxt_vld_q;
            cur_last_d = nxt_last_q;
            cur_data_d = nxt_data_q;
            nxt_vld_d  = 1'b0;
            cursor_d   = cursor_t'(sum - LB_W);
        end else if (fire) begin
            cursor_d   = cursor_t'(sum);
        end
        // Accept implies nxt was empty, so a popping cur leaves cur free for the new line.
        if (accept && (!cur_vld_q || pop)) begin
            cur_vld_d  = 1'b1;
            cur_last_d = bus.line_last;
            cur_data_d = bus.line_data;
        end else if (accept) begin
            nxt_vld_d  = 1'b1;
            nxt_last_d = bus.line_last;
            nxt_data_d = bus.line_data;
        end
        if (bus.flush) begin
            cur_vld_d  = 1'b0;
            nxt_vld_d  = 1'b0;
            cursor_d   = '0;
            err_d      = 1'b0;
            msg_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_vld_q  <= 1'b0;
            cur_last_q <= 1'b0;
            cur_data_q <= '0;
            nxt_vld_q  <= 1'b0;
            nxt_last_q <= 1'b0;
            nxt_data_q <= '0;
            cursor_q   <= '0;
            err_q      <= 1'b0;
            msg_done_q <= 1'b0;
        end else begin
            cur_vld_q  <= cur_vld_d;
            cur_last_q <= cur_last_d;
            cur_data_q <= cur_data_d;
            nxt_vld_q  <= nxt_vld_d;
            nxt_last_q <= nxt_last_d;
            nxt_data_q <= nxt_data_d;
            cursor_q   <= cursor_d;
            err_q      <= err_d;
            msg_done_q <= msg_done_d;
        end
    end
endmodule

// File: tb/tb_fetch_window_aligner.sv
// tb_fetch_window_aligner: directed self-checking bench for fetch_window_aligner.
module tb_fetch_window_aligner;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    fetch_window_aligner_if bus ();

    fetch_window_aligner u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mkline(input int base);
        logic [511:0] r;
        for (int k = 0; k < 64; k++) r[8*k +: 8] = 8'(base + k);
        return r;
    endfunction

    function automatic logic [79:0] wexp(input int start, input int n);
        logic [79:0] r;
        for (int i = 0; i < 10; i++) r[8*i +: 8] = (i < n) ? 8'(start + i) : 8'h00;
        return r;
    endfunction

    task automatic send_line(input int base, input logic last);
        bit done;
        done = 0;
        bus.line_valid = 1'b1;
        bus.line_data  = mkline(base);
        bus.line_last  = last;
        for (int t = 0; t < 20 && !done; t++) begin
            done = bus.line_ready;
            @(negedge clk);
        end
        if (!done) chk("send_rdy", 80'(bus.line_ready), 80'(1));
        bus.line_valid = 1'b0;
    endtask

    task automatic consume(input int n);
        bus.consume_valid = 1'b1;
        bus.consume_bytes = 4'(n);
        @(negedge clk);
        bus.consume_valid = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    initial begin
        bus.line_valid = 0; bus.line_data = '0; bus.line_last = 0;
        bus.flush = 0; bus.consume_valid = 0; bus.consume_bytes = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", 80'(bus.line_ready), 80'(1));
        chk("rst_wvalid", 80'(bus.win_valid), 80'(0));
        chk("rst_wbytes", 80'(bus.win_bytes), 80'(0));
        chk("rst_wdata", bus.win_data, 80'(0));
        chk("rst_err", 80'(bus.err), 80'(0));

        send_line(8'h00, 1'b0);
        chk("t1_wvalid", 80'(bus.win_valid), 80'(1));
        chk("t1_wbytes", 80'(bus.win_bytes), 80'(10));
        chk("t1_wdata", bus.win_data, wexp(8'h00, 10));
        chk("t1_ready", 80'(bus.line_ready), 80'(1));

        send_line(8'h40, 1'b0);
        chk("t2_ready_full", 80'(bus.line_ready), 80'(0));
        repeat (6) consume(10);
        chk("t2_wdata60", bus.win_data, wexp(8'h3C, 10));
        consume(6);
        chk("t2_wdata_pop", bus.win_data, wexp(8'h42, 10));
        chk("t2_ready_pop", 80'(bus.line_ready), 80'(1));
        repeat (5) consume(10);
        consume(2);
        chk("t2_wdata54", bus.win_data, wexp(8'h76, 10));
        bus.line_valid = 1'b1; bus.line_data = mkline(8'h80); bus.line_last = 1'b0;
        consume(10);
        bus.line_valid = 1'b0;
        chk("t2_sim_wdata", bus.win_data, wexp(8'h80, 10));
        chk("t2_sim_ready", 80'(bus.line_ready), 80'(1));
        chk("t2_sim_wbytes", 80'(bus.win_bytes), 80'(10));
        do_flush();

        send_line(8'h00, 1'b1);
        repeat (5) consume(10);
        consume(8);
        chk("t3_wbytes", 80'(bus.win_bytes), 80'(6));
        chk("t3_wvalid", 80'(bus.win_valid), 80'(1));
        chk("t3_wdata", bus.win_data, wexp(8'h3A, 6));
        consume(7);
        chk("t3_err", 80'(bus.err), 80'(1));
        chk("t3_err_wdata", bus.win_data, wexp(8'h3A, 6));
        consume(6);
        chk("t3_done", 80'(bus.msg_done), 80'(1));
        chk("t3_done_wvalid", 80'(bus.win_valid), 80'(0));
        chk("t3_done_wbytes", 80'(bus.win_bytes), 80'(0));
        @(negedge clk);
        chk("t3_done_pulse", 80'(bus.msg_done), 80'(0));
        chk("t3_err_sticky", 80'(bus.err), 80'(1));
        do_flush();
        chk("t3_flush_err", 80'(bus.err), 80'(0));

        send_line(8'h00, 1'b0);
        send_line(8'h40, 1'b0);
        bus.line_valid = 1'b1; bus.line_data = mkline(8'h80); bus.line_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_ready", 80'(bus.line_ready), 80'(0));
        chk("t4_hold_wdata", bus.win_data, wexp(8'h00, 10));
        repeat (6) consume(10);
        consume(6);
        chk("t4_pop_ready", 80'(bus.line_ready), 80'(1));
        @(negedge clk);
        bus.line_valid = 1'b0;
        chk("t4_refill_ready", 80'(bus.line_ready), 80'(0));
        chk("t4_wdata", bus.win_data, wexp(8'h42, 10));
        repeat (5) consume(10);
        consume(6);
        chk("t4_cross", bus.win_data, wexp(8'h7A, 10));
        do_flush();

        send_line(8'h00, 1'b0);
        consume(10);
        consume(11);
        chk("t5_err", 80'(bus.err), 80'(1));
        bus.flush = 1'b1; bus.consume_valid = 1'b1; bus.consume_bytes = 4'd3;
        bus.line_valid = 1'b1; bus.line_data = mkline(8'h40);
        @(negedge clk);
        bus.flush = 1'b0; bus.consume_valid = 1'b0; bus.line_valid = 1'b0;
        chk("t5_wvalid", 80'(bus.win_valid), 80'(0));
        chk("t5_wbytes", 80'(bus.win_bytes), 80'(0));
        chk("t5_wdata", bus.win_data, 80'(0));
        chk("t5_err_clr", 80'(bus.err), 80'(0));
        chk("t5_ready", 80'(bus.line_ready), 80'(1));
        @(negedge clk);
        chk("t5_not_taken", 80'(bus.win_valid), 80'(0));

        send_line(8'h00, 1'b0);
        send_line(8'h40, 1'b0);
        consume(11);
        chk("t6_err", 80'(bus.err), 80'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_wvalid", 80'(bus.win_valid), 80'(0));
        chk("t6_wbytes", 80'(bus.win_bytes), 80'(0));
        chk("t6_err", 80'(bus.err), 80'(0));
        chk("t6_ready", 80'(bus.line_ready), 80'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_wvalid", 80'(bus.win_valid), 80'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
